// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle processor: opcodes, FSM states, field positions.
// Pure declarations; no timing or handshake behaviour.
package mc_pkg;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 25;
  localparam int RD_HI  = 24;
  localparam int RD_LO  = 22;
  localparam int RA_HI  = 21;
  localparam int RA_LO  = 19;
  localparam int RB_HI  = 18;
  localparam int RB_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [6:0] OP_ADD  = 7'h00;
  localparam logic [6:0] OP_SUB  = 7'h01;
  localparam logic [6:0] OP_AND  = 7'h02;
  localparam logic [6:0] OP_OR   = 7'h03;
  localparam logic [6:0] OP_ADDI = 7'h04;
  localparam logic [6:0] OP_LD   = 7'h05;
  localparam logic [6:0] OP_ST   = 7'h06;
  localparam logic [6:0] OP_BEQ  = 7'h07;
  localparam logic [6:0] OP_BNE  = 7'h08;
  localparam logic [6:0] OP_BLT  = 7'h09;
  localparam logic [6:0] OP_JMP  = 7'h0A;
  localparam logic [6:0] OP_HALT = 7'h7F;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_e;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU producing result and {c,v,n,z}; zero latency, no handshake.
// SUB carry is the no-borrow flag (a >= b unsigned).
module mc_alu
  import mc_pkg::*;
#(
  parameter int DW = 16
) (
  input  alu_op_e         op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   result,
  output logic            c,
  output logic            v,
  output logic            n,
  output logic            z
);

  logic [DW:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      ALU_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0];
        c      = sum[DW];
        v      = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
        result = sum[DW-1:0];
        c      = sum[DW];
        v      = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
    n = result[DW-1];
    z = (result == '0);
  end

endmodule

// File: rtl/mc_processor.sv
// Multicycle FETCH/EXEC/MEM processor; ALU/branch take fetch wait + 2 cycles, LD/ST add the data wait.
// Fetch and data requests are held until ivalid/dvalid; there is no timeout.
module mc_processor
  import mc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic [DW-1:0] pc,
  output logic          ireq,
  input  logic [31:0]   instr,
  input  logic          ivalid,
  output logic          dreq,
  output logic          memwrite,
  output logic [DW-1:0] alusrca,
  output logic [DW-1:0] alusrcb,
  input  logic [DW-1:0] memdout,
  input  logic          dvalid,
  output logic          halted,
  output logic [3:0]    flags
);

  localparam logic [2:0] IDX_MASK = 3'(NREG - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [3:0]    flags_q, flags_d;
  logic [DW-1:0] regs_q [8];
  logic [DW-1:0] regs_d [8];

  logic [6:0]    op;
  logic [2:0]    rd_i, ra_i, rb_i;
  logic [DW-1:0] imm_dw, ra_val, rb_val, alu_b, alu_res, pc_inc, pc_br;
  alu_op_e       alu_op;
  logic          alu_c, alu_v, alu_n, alu_z;
  logic          is_alu, taken;

  assign op     = instr_q[OP_HI:OP_LO];
  assign rd_i   = instr_q[RD_HI:RD_LO] & IDX_MASK;
  assign ra_i   = instr_q[RA_HI:RA_LO] & IDX_MASK;
  assign rb_i   = instr_q[RB_HI:RB_LO] & IDX_MASK;
  assign imm_dw = DW'($signed(instr_q[IMM_HI:IMM_LO]));
  // r0 is never written, so it reads back as its reset value of zero.
  assign ra_val = regs_q[ra_i];
  assign rb_val = regs_q[rb_i];
  assign pc_inc = pc_q + DW'(1);
  assign pc_br  = pc_inc + imm_dw;

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = imm_dw;
    is_alu = 1'b0;
    taken  = 1'b0;
    case (op)
      OP_ADD:  begin alu_b = rb_val; is_alu = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB; alu_b = rb_val; is_alu = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND; alu_b = rb_val; is_alu = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  alu_b = rb_val; is_alu = 1'b1; end
      OP_ADDI: is_alu = 1'b1;
      OP_BEQ:  taken = flags_q[0];
      OP_BNE:  taken = !flags_q[0];
      OP_BLT:  taken = flags_q[1] ^ flags_q[2];
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  mc_alu #(.DW(DW)) u_alu (
    .op     (alu_op),
    .a      (ra_val),
    .b      (alu_b),
    .result (alu_res),
    .c      (alu_c),
    .v      (alu_v),
    .n      (alu_n),
    .z      (alu_z)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    flags_d  = flags_q;
    regs_d   = regs_q;
    ireq     = 1'b0;
    dreq     = 1'b0;
    memwrite = 1'b0;
    halted   = 1'b0;
    case (state_q)
      FETCH: begin
        ireq = 1'b1;
        if (ivalid) begin
          instr_d = instr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_inc;
        if (is_alu) begin
          if (rd_i != 3'd0) regs_d[rd_i] = alu_res;
          flags_d = {alu_c, alu_v, alu_n, alu_z};
        end else if (op == OP_LD || op == OP_ST) begin
          state_d = MEM;
          pc_d    = pc_q;
        end else if (op == OP_HALT) begin
          state_d = HALT;
          pc_d    = pc_q;
        end else if (taken) begin
          pc_d = pc_br;
        end
      end
      MEM: begin
        // Address and store data come straight from the ALU and register file,
        // which cannot change while the access is outstanding.
        dreq     = 1'b1;
        memwrite = (op == OP_ST);
        if (dvalid) begin
          if (op == OP_LD && rd_i != 3'd0) regs_d[rd_i] = memdout;
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      HALT:    halted = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      instr_q <= '0;
      flags_q <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      flags_q <= flags_d;
      regs_q  <= regs_d;
    end
  end

  assign pc      = pc_q;
  assign flags   = flags_q;
  assign alusrca = alu_res;
  assign alusrcb = rb_val;

endmodule

// File: tb/tb_mc_processor.sv
// Lockstep bench: an instruction-level model predicts every fetch, data access and flag update.
module tb_mc_processor;

  localparam int DW   = 16;
  localparam int NREG = 8;

  localparam logic [6:0] ADD = 7'h00, SUB = 7'h01, ADDI = 7'h04, LD = 7'h05, ST = 7'h06;
  localparam logic [6:0] BEQ = 7'h07, BNE = 7'h08, BLT = 7'h09, JMP = 7'h0A, HLT = 7'h7F;
  localparam logic [6:0] NOP = 7'h20;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] pc;
  logic          ireq;
  logic [31:0]   instr;
  logic          ivalid;
  logic          dreq;
  logic          memwrite;
  logic [DW-1:0] alusrca;
  logic [DW-1:0] alusrcb;
  logic [DW-1:0] memdout;
  logic          dvalid;
  logic          halted;
  logic [3:0]    flags;

  mc_processor #(.DW(DW), .NREG(NREG)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .ireq     (ireq),
    .instr    (instr),
    .ivalid   (ivalid),
    .dreq     (dreq),
    .memwrite (memwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .memdout  (memdout),
    .dvalid   (dvalid),
    .halted   (halted),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_pc;
  logic [15:0] m_regs [NREG];
  logic [3:0]  m_flags;
  logic [15:0] dmem [logic [15:0]];
  logic [15:0] last_st_addr, last_st_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb,
                                      input logic [15:0] imm);
    return {op, rd, ra, rb, imm};
  endfunction

  function automatic longint sval(input longint x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  task automatic model_reset();
    m_pc    = '0;
    m_flags = '0;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    dmem.delete();
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    ivalid = 1'b0;
    dvalid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_dreq", dreq, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_pc", pc, 0);
    check_val("rst_flags", flags, 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_val("rel_ireq", ireq, 1);
  endtask

  // Called at a negedge where the DUT should be presenting a fetch; returns at the
  // negedge where the following fetch (or halt) is visible.
  task automatic exec_one(input logic [31:0] w, input int fwait, input int dwait);
    logic [6:0]  op;
    int          rd, ra, rb;
    logic [15:0] imm, res, addr, ld;
    longint      ua, ub, r, sr;
    logic        c, v;
    bit          is_alu, taken;

    check_val("fetch_ireq", ireq, 1);
    check_val("fetch_pc", pc, m_pc);
    check_val("flags", flags, m_flags);
    for (int i = 0; i < fwait; i++) begin
      ivalid = 1'b0;
      dvalid = 1'($urandom % 2);
      instr  = $urandom;
      @(negedge clk);
      check_val("wait_ireq", ireq, 1);
      check_val("wait_pc", pc, m_pc);
    end
    instr  = w;
    ivalid = 1'b1;
    dvalid = 1'b0;
    @(negedge clk);
    check_val("exec_quiet", {ireq, dreq, halted}, 0);
    ivalid = 1'b1;
    instr  = $urandom;

    op  = w[31:25];
    rd  = int'(w[24:22]) % NREG;
    ra  = int'(w[21:19]) % NREG;
    rb  = int'(w[18:16]) % NREG;
    imm = w[15:0];
    ua  = longint'(m_regs[ra]);
    ub  = (op == ADDI) ? longint'(imm) : longint'(m_regs[rb]);
    is_alu = 1'b1;
    c = 1'b0;
    sr = 0;
    case (op)
      ADD, ADDI: begin r = ua + ub; c = (r > 65535); sr = sval(ua) + sval(ub); end
      SUB:       begin r = ua - ub; c = (ua >= ub);  sr = sval(ua) - sval(ub); end
      7'h02:     r = ua & ub;
      7'h03:     r = ua | ub;
      default:   begin r = 0; is_alu = 1'b0; end
    endcase
    v   = (op == ADD || op == ADDI || op == SUB) && (sr > 32767 || sr < -32768);
    res = 16'(r);

    @(negedge clk);
    ivalid = 1'b0;
    if (is_alu) begin
      if (rd != 0) m_regs[rd] = res;
      m_flags = {c, v, res[15], res == 16'h0};
      m_pc    = m_pc + 16'd1;
    end else if (op == LD || op == ST) begin
      addr = m_regs[ra] + imm;
      check_val("mem_dreq", dreq, 1);
      check_val("mem_write", memwrite, (op == ST));
      check_val("mem_addr", alusrca, addr);
      if (op == ST) check_val("mem_wdata", alusrcb, m_regs[rb]);
      last_st_addr = alusrca;
      last_st_data = alusrcb;
      for (int i = 0; i < dwait; i++) begin
        dvalid = 1'b0;
        ivalid = 1'($urandom % 2);
        instr  = $urandom;
        @(negedge clk);
        check_val("memw_dreq", {ireq, dreq}, 2'b01);
        check_val("memw_addr", alusrca, addr);
      end
      if (op == ST) begin
        dmem[addr] = m_regs[rb];
      end else begin
        ld = dmem.exists(addr) ? dmem[addr] : 16'($urandom);
      end
      memdout = (op == LD) ? ld : 16'($urandom);
      dvalid  = 1'b1;
      ivalid  = 1'b0;
      @(negedge clk);
      dvalid = 1'b0;
      if (op == LD && rd != 0) m_regs[rd] = ld;
      m_pc = m_pc + 16'd1;
    end else if (op == HLT) begin
      for (int i = 0; i < 4; i++) begin
        check_val("halt_state", {halted, ireq, dreq}, 3'b100);
        ivalid = 1'b1;
        dvalid = 1'b1;
        instr  = $urandom;
        @(negedge clk);
      end
      ivalid = 1'b0;
      dvalid = 1'b0;
    end else begin
      taken = (op == BEQ && m_flags[0]) || (op == BNE && !m_flags[0]) ||
              (op == BLT && (m_flags[1] ^ m_flags[2])) || (op == JMP);
      m_pc = taken ? m_pc + 16'd1 + imm : m_pc + 16'd1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [6:0]  op;
    logic [15:0] imm;
    k = $urandom_range(0, 11);
    op = (k == 11) ? 7'($urandom_range(11, 126)) : 7'(k);
    if (op >= BEQ && op <= JMP)
      imm = 16'($signed($urandom_range(0, 8)) - 4);
    else if ($urandom % 2 == 0)
      imm = 16'($urandom_range(0, 40));
    else
      imm = 16'($urandom);
    return enc(op, 3'($urandom), 3'($urandom), 3'($urandom), imm);
  endfunction

  initial begin
    reset   = 1'b0;
    ivalid  = 1'b0;
    dvalid  = 1'b0;
    instr   = '0;
    memdout = '0;
    do_reset();

    exec_one(enc(ADDI, 1, 0, 0, 16'd5), 0, 0);
    exec_one(enc(ADDI, 2, 0, 0, 16'hFFFB), 1, 0);
    exec_one(enc(ADD, 3, 1, 2, 16'h0), 0, 0);
    check_val("add_zero_flags", flags, 4'b1001);
    exec_one(enc(ST, 0, 0, 1, 16'h0020), 0, 0);
    check_val("r1_five", last_st_data, 16'h0005);
    exec_one(enc(ST, 0, 0, 2, 16'h0021), 0, 1);
    check_val("r2_minus5", last_st_data, 16'hFFFB);
    exec_one(enc(ST, 0, 0, 3, 16'h0022), 0, 0);
    check_val("r3_zero", last_st_data, 16'h0000);

    exec_one(enc(ADDI, 1, 0, 0, 16'h7FFF), 0, 0);
    exec_one(enc(ADD, 1, 1, 1, 16'h0), 0, 0);
    check_val("ovf_flags", flags, 4'b0110);
    exec_one(enc(ST, 0, 0, 1, 16'h0023), 0, 0);
    check_val("ovf_result", last_st_data, 16'hFFFE);
    exec_one(enc(ADDI, 1, 0, 0, 16'd1), 0, 0);
    exec_one(enc(SUB, 2, 0, 1, 16'h0), 0, 0);
    check_val("sub_flags", flags, 4'b0010);
    exec_one(enc(ST, 0, 0, 2, 16'h0024), 0, 0);
    check_val("sub_result", last_st_data, 16'hFFFF);

    exec_one(enc(ST, 0, 0, 1, 16'd10), 0, 3);
    check_val("st_addr", last_st_addr, 16'h000A);
    check_val("st_data", last_st_data, 16'h0001);
    exec_one(enc(LD, 4, 0, 0, 16'd10), 2, 2);
    exec_one(enc(ST, 0, 0, 4, 16'd11), 0, 0);
    check_val("ld_value", last_st_data, 16'h0001);
    check_val("ld_flags", flags, 4'b0010);

    do_reset();
    exec_one(enc(JMP, 0, 0, 0, 16'hFFFF), 0, 0);
    check_val("jmp_self", pc, 16'h0000);
    exec_one(enc(ADDI, 1, 0, 0, 16'd3), 0, 0);
    exec_one(enc(NOP, 1, 1, 1, 16'h1234), 0, 0);
    exec_one(enc(NOP, 0, 0, 0, 16'h0), 0, 0);
    exec_one(enc(SUB, 3, 0, 0, 16'h0), 0, 0);
    check_val("pc_before_beq", pc, 16'd4);
    exec_one(enc(BEQ, 0, 0, 0, 16'hFFFF), 0, 0);
    check_val("beq_taken", pc, 16'd4);
    exec_one(enc(BNE, 0, 0, 0, 16'hFFFF), 0, 0);
    check_val("bne_not_taken", pc, 16'd5);
    exec_one(enc(BLT, 0, 0, 0, 16'h0010), 0, 0);
    check_val("blt_not_taken", pc, 16'd6);
    exec_one(enc(JMP, 0, 0, 0, 16'hFFF8), 0, 0);
    check_val("jmp_back", pc, 16'hFFFF);
    exec_one(enc(NOP, 0, 0, 0, 16'h0), 0, 0);
    check_val("pc_wrap", pc, 16'h0000);

    exec_one(enc(ADDI, 5, 0, 0, 16'd9), 5, 0);
    check_val("pre_abort_pc", pc, m_pc);
    instr  = enc(LD, 5, 0, 0, 16'd20);
    ivalid = 1'b1;
    @(negedge clk);
    ivalid = 1'b0;
    @(negedge clk);
    check_val("abort_dreq_before", dreq, 1);
    reset   = 1'b0;
    dvalid  = 1'b1;
    memdout = 16'h1234;
    @(negedge clk);
    check_val("abort_dreq_after", dreq, 0);
    reset  = 1'b1;
    dvalid = 1'b0;
    model_reset();
    @(negedge clk);
    check_val("abort_pc", pc, 16'h0000);
    exec_one(enc(ST, 0, 0, 5, 16'h0), 0, 0);
    check_val("abort_no_wb", last_st_data, 16'h0000);
    exec_one(enc(HLT, 0, 0, 0, 16'h0), 0, 0);

    do_reset();
    for (int i = 0; i < 400; i++)
      exec_one(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3));
    exec_one(enc(HLT, 0, 0, 0, 16'h0), 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
